ndro_bank: RTL and testbench
============================

Name: ndro_bank

Overview:
- Parametrised behavioural model of a bank of WIDTH RSFQ NDRO cells for VCD timing-assertion testing.
- Each channel has its own set/clr pulse lines. All channels share one readout pulse line, clk.
- A mode parameter selects non-destructive or destructive readout.
- A built-in monitor counts hold-window violations. This supersedes single-cell NDRO models in the timing-check test suites.

Parameters:
- WIDTH, 4, number of NDRO channels.
- DESTRUCTIVE, 0, 0 = NDRO (state kept after readout); 1 = DRO (state cleared by readout).
- DELAY_CLK_OUT, 7.0, clk-pulse to out-toggle delay in ps (timescale 1ps/100fs).
- CT_CLR_SET, 2.5, minimum ps from a clr pulse to a following set pulse on the same channel.
- CT_CLK_CLR, 2.5, minimum ps from a clk pulse to a following clr pulse on a channel in state 1.
- BEGIN_TIME, 8, ps after time 0 at which channels leave the uninitialised state.
- CNT_W, 8, width of the violation counter.

Ports:
- clk  input  1  shared readout pulse line.
- reset  input  1  reset, asynchronous, active-high.
- set  input  WIDTH  per-channel set pulse lines.
- clr  input  WIDTH  per-channel clear pulse lines.
- out  output  WIDTH  per-channel output pulse lines (a toggle is one pulse).
- state_q  output  WIDTH  current channel state (debug visibility).
- viol  output  1  sticky flag: at least one violation since reset.
- viol_cnt  output  CNT_W  saturating violation count.

Behaviour:
- Pulse semantics: every 0->1 or 1->0 transition on clk/set/clr[i] is one pulse. Transitions to or from X/Z are ignored.
- Initial state: state_q = all X, out = 0, viol = 0, viol_cnt = 0. At BEGIN_TIME all channels go to 0. Pulses before BEGIN_TIME are ignored and not counted.
- reset high:
  - Immediately forces state_q = 0, out = 0, viol = 0, viol_cnt = 0.
  - Cancels every out toggle scheduled but not yet applied (per-channel epoch tag).
  - All pulses are ignored while reset is high.
  - On reset fall, channels stay 0 with no BEGIN_TIME re-wait. Reset asserted before BEGIN_TIME also ends the X state.
- Per-channel state machine, states 0 and 1:
  - 0 + set -> 1.
  - 1 + set -> 1 (absorbed).
  - 1 + clr -> 0.
  - 0 + clr -> 0.
  - clk in 0: no effect.
  - clk in 1: schedule an out[i] toggle at now + DELAY_CLK_OUT. If DESTRUCTIVE = 1, state -> 0 in the same timestep.
- Same-timestep ordering per channel: clk is evaluated first on the pre-timestep state, then clr, then set.
  - Example: clk + set on a state-0 channel produces no toggle; the state ends at 1.
  - Simultaneous set and clr: clr wins, final state 0, and one violation is counted.
- Multiple readouts in flight: clk pulses spaced less than DELAY_CLK_OUT apart each schedule their own toggle (transport delay, no pulse swallowing).
- Violations (monitor logic; channel index is irrelevant to the count):
  - set[i] arriving less than CT_CLR_SET after the last clr[i] pulse, in either state.
  - clr[i] arriving less than CT_CLK_CLR after the last clk pulse while channel i was in state 1 at that clk.
  - A distance of 0 counts as a violation.
  - Each violation sets viol and increments viol_cnt, saturating at 2^CNT_W-1.
  - A violation does not alter state transitions.
- state_q reflects state with zero delay.

Optional Feature:
- Macro: NDRO_BANK_VIOL_MON_EN.
- Defined:
  - The violation monitor above is active.
  - Each violation also prints one $display line with $realtime, channel index and check name.
- Undefined:
  - No monitor logic or last-pulse timestamps are compiled.
  - viol is tied to 0 and viol_cnt to 0.
  - State and out behaviour are identical to the defined build.

Test Plan:
- Init: WIDTH=4, pulse clk at t=5 and set[0] at t=6 -> no out toggle, state_q stays X until t=8, then 0.
- NDRO readout: set[1] at t=20; clk at t=30 and t=40 -> out[1] toggles at t=37 and t=47, state_q[1]=1 throughout, other outs unchanged.
- DRO mode: DESTRUCTIVE=1; set[2] at t=20; clk at t=30, t=40 -> single out[2] toggle at t=37, state_q[2]=0 from t=30.
- Hold violations (feature on): clr[0] at t=50, set[0] at t=51 -> viol=1, viol_cnt=1, state_q[0]=1. Then clk at t=60, clr[0] at t=61 -> viol_cnt=2, state_q[0]=0.
- Reset mid-flight: set[3] at t=20, clk at t=30, reset high t=32..35 -> no toggle at t=37, out=0, viol_cnt=0, and set[3] at t=33 ignored.
- Saturation: CNT_W=2, five simultaneous set/clr pairs on channel 0 spaced 10ps -> viol_cnt stops at 3, state_q[0]=0.

Source files
------------

// File: rtl/ndro_bank.sv
`timescale 1ps/100fs
// ndro_bank: pulse-level behavioural model of WIDTH RSFQ NDRO (or DRO) cells sharing one readout line.
// Define NDRO_BANK_VIOL_MON_EN to compile the hold-window violation monitor; otherwise viol/viol_cnt read 0.
module ndro_bank #(
   parameter int unsigned WIDTH         = 4,
   parameter bit          DESTRUCTIVE   = 1'b0,
   parameter real         DELAY_CLK_OUT = 7.0,
   parameter real         CT_CLR_SET    = 2.5,
   parameter real         CT_CLK_CLR    = 2.5,
   parameter real         BEGIN_TIME    = 8.0,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] set,
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] state_q,
   output logic             viol,
   output logic [CNT_W-1:0] viol_cnt
);

   logic [WIDTH-1:0] st_r;
   logic [WIDTH-1:0] out_r      = '0;
   logic             ready_r    = 1'b0;
   logic             begin_tick = 1'b0;
   int unsigned      epoch_r    = 0;
   logic             clk_d;
   logic [WIDTH-1:0] set_d;
   logic [WIDTH-1:0] clr_d;

`ifdef NDRO_BANK_VIOL_MON_EN
   localparam real NEVER = -1.0e12;

   logic             viol_r = 1'b0;
   logic [CNT_W-1:0] cnt_r  = '0;
   real              last_clr_t  [WIDTH];
   real              last_clk1_t [WIDTH];

   task automatic clear_stamps();
      for (int i = 0; i < int'(WIDTH); i++) begin
         last_clr_t[i]  = NEVER;
         last_clk1_t[i] = NEVER;
      end
   endtask

   task automatic note_viol(input int unsigned ch, input string check);
      viol_r = 1'b1;
      if (cnt_r != {CNT_W{1'b1}}) cnt_r = cnt_r + CNT_W'(1);
      $display("%t %m: %s hold-window violation on channel %0d", $realtime, check, ch);
   endtask
`endif

   // Transport-delay readout: every launch toggles out unless a reset bumped the epoch meanwhile.
   task automatic launch(input int unsigned ch, input int unsigned ep);
      fork
         begin
            #(DELAY_CLK_OUT);
            if (epoch_r == ep) out_r[ch] = ~out_r[ch];
         end
      join_none
   endtask

   // Channels leave the uninitialised state once BEGIN_TIME has elapsed.
   always #(BEGIN_TIME) begin_tick = 1'b1;

   always @(clk, reset, set, clr, begin_tick) begin : model
      logic             clk_p;
      logic [WIDTH-1:0] set_p;
      logic [WIDTH-1:0] clr_p;
      logic             pre;

      // A pulse is any clean 0<->1 transition; edges to or from X/Z are dropped.
      clk_p = (clk_d !== clk) && !$isunknown({clk_d, clk});
      for (int i = 0; i < int'(WIDTH); i++) begin
         set_p[i] = (set_d[i] !== set[i]) && !$isunknown({set_d[i], set[i]});
         clr_p[i] = (clr_d[i] !== clr[i]) && !$isunknown({clr_d[i], clr[i]});
      end
      clk_d = clk;
      set_d = set;
      clr_d = clr;

      if (reset === 1'b1) begin
         st_r    = '0;
         out_r   = '0;
         ready_r = 1'b1;
         epoch_r = epoch_r + 1;
`ifdef NDRO_BANK_VIOL_MON_EN
         viol_r = 1'b0;
         cnt_r  = '0;
         clear_stamps();
`endif
      end else if (!ready_r) begin
         if (begin_tick) begin
            ready_r = 1'b1;
            st_r    = '0;
`ifdef NDRO_BANK_VIOL_MON_EN
            clear_stamps();
`endif
         end
      end else begin
         // Per channel: readout on the pre-timestep state, then clear, then set (clear wins a tie).
         for (int i = 0; i < int'(WIDTH); i++) begin
            pre = st_r[i];
            if (clk_p && pre) begin
               launch(i, epoch_r);
               if (DESTRUCTIVE) st_r[i] = 1'b0;
`ifdef NDRO_BANK_VIOL_MON_EN
               last_clk1_t[i] = $realtime;
`endif
            end
            if (clr_p[i]) begin
`ifdef NDRO_BANK_VIOL_MON_EN
               if ($realtime - last_clk1_t[i] < CT_CLK_CLR) note_viol(i, "clk->clr");
               last_clr_t[i] = $realtime;
`endif
               st_r[i] = 1'b0;
            end
            if (set_p[i]) begin
`ifdef NDRO_BANK_VIOL_MON_EN
               if ($realtime - last_clr_t[i] < CT_CLR_SET) note_viol(i, "clr->set");
`endif
               if (!clr_p[i]) st_r[i] = 1'b1;
            end
         end
      end
   end

   assign state_q = st_r;
   assign out     = out_r;

`ifdef NDRO_BANK_VIOL_MON_EN
   assign viol     = viol_r;
   assign viol_cnt = cnt_r;
`else
   assign viol     = 1'b0;
   assign viol_cnt = '0;
`endif

endmodule

// File: tb/tb_ndro_bank.sv
`timescale 1ps/100fs
// tb_ndro_bank: NDRO, DRO and 2-bit-counter instances on shared pulse lines, checked against an
// event-list reference model (out = parity of readout events that have matured since the last reset).
module tb_ndro_bank;

   localparam int unsigned W   = 4;
   localparam int          NM  = 3;
   localparam real         DLY = 7.0;
   localparam real         CT  = 2.5;
   localparam real         BT  = 8.0;
`ifdef NDRO_BANK_VIOL_MON_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif

   typedef struct {
      int  m;
      int  ch;
      real t;
   } tog_t;

   logic         clk;
   logic         reset;
   logic [W-1:0] set;
   logic [W-1:0] clr;
   logic [W-1:0] out_n, st_n, out_d, st_d, out_s, st_s;
   logic         viol_n, viol_d, viol_s;
   logic [7:0]   cnt_n, cnt_d;
   logic [1:0]   cnt_s;

   ndro_bank #(.WIDTH(W)) u_ndro (
      .clk(clk), .reset(reset), .set(set), .clr(clr),
      .out(out_n), .state_q(st_n), .viol(viol_n), .viol_cnt(cnt_n));

   ndro_bank #(.WIDTH(W), .DESTRUCTIVE(1'b1)) u_dro (
      .clk(clk), .reset(reset), .set(set), .clr(clr),
      .out(out_d), .state_q(st_d), .viol(viol_d), .viol_cnt(cnt_d));

   ndro_bank #(.WIDTH(W), .CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .set(set), .clr(clr),
      .out(out_s), .state_q(st_s), .viol(viol_s), .viol_cnt(cnt_s));

   int   n_pass  = 0;
   int   n_total = 0;
   tog_t togq[$];
   bit   m_ready;
   bit   m_st     [NM][W];
   bit   m_viol   [NM];
   int   m_cnt    [NM];
   real  m_clr_t  [NM][W];
   real  m_clk1_t [NM][W];

   function automatic int cmax(input int m);
      return (m == 2) ? 3 : 255;
   endfunction

   task automatic model_clear();
      togq.delete();
      for (int m = 0; m < NM; m++) begin
         m_viol[m] = 1'b0;
         m_cnt[m]  = 0;
         for (int c = 0; c < int'(W); c++) begin
            m_st[m][c]     = 1'b0;
            m_clr_t[m][c]  = -1.0e9;
            m_clk1_t[m][c] = -1.0e9;
         end
      end
   endtask

   task automatic bump(input int m);
      m_viol[m] = 1'b1;
      if (m_cnt[m] < cmax(m)) m_cnt[m]++;
   endtask

   // Drive pulses (line toggles) in one step and advance the reference model.
   task automatic apply(input bit c, input logic [W-1:0] s, input logic [W-1:0] r);
      real now;
      bit  fire;
      now = $realtime;
      if (c) clk = ~clk;
      set = set ^ s;
      clr = clr ^ r;
      if (!m_ready && now > BT) m_ready = 1'b1;
      if (reset || !m_ready) return;
      for (int m = 0; m < NM; m++) begin
         for (int ch = 0; ch < int'(W); ch++) begin
            fire = c && m_st[m][ch];
            if (fire) begin
               tog_t e;
               e.m = m; e.ch = ch; e.t = now + DLY;
               togq.push_back(e);
               m_clk1_t[m][ch] = now;
            end
            if (MON) begin
               if (r[ch] && (now - m_clk1_t[m][ch] < CT)) bump(m);
               if (s[ch] && (r[ch] || (now - m_clr_t[m][ch] < CT))) bump(m);
            end
            if (r[ch]) m_clr_t[m][ch] = now;
            if (r[ch])                   m_st[m][ch] = 1'b0;
            else if (s[ch])              m_st[m][ch] = 1'b1;
            else if (fire && (m == 1))   m_st[m][ch] = 1'b0;
         end
      end
   endtask

   task automatic do_reset_model();
      model_clear();
      m_ready = 1'b1;
   endtask

   function automatic bit exp_out(input int m, input int ch);
      bit p;
      p = 1'b0;
      foreach (togq[k]) if (togq[k].m == m && togq[k].ch == ch && togq[k].t <= $realtime) p = ~p;
      return p;
   endfunction

   task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %0h expected %0h at %0t", name, obs, expv, $realtime);
   endtask

   task automatic check_all(input string tag, input bit with_state);
      logic [W-1:0] e_st, e_out, o_st, o_out;
      logic [7:0]   o_cnt;
      logic         o_viol;
      for (int m = 0; m < NM; m++) begin
         for (int ch = 0; ch < int'(W); ch++) begin
            e_st[ch]  = m_st[m][ch];
            e_out[ch] = exp_out(m, ch);
         end
         case (m)
            0:       begin o_st = st_n; o_out = out_n; o_viol = viol_n; o_cnt = cnt_n; end
            1:       begin o_st = st_d; o_out = out_d; o_viol = viol_d; o_cnt = cnt_d; end
            default: begin o_st = st_s; o_out = out_s; o_viol = viol_s; o_cnt = 8'(cnt_s); end
         endcase
         if (with_state) chk($sformatf("%s/u%0d state_q", tag, m), 8'(o_st), 8'(e_st));
         chk($sformatf("%s/u%0d out", tag, m), 8'(o_out), 8'(e_out));
         chk($sformatf("%s/u%0d viol", tag, m), 8'(o_viol), 8'(m_viol[m]));
         chk($sformatf("%s/u%0d viol_cnt", tag, m), o_cnt, 8'(m_cnt[m]));
      end
   endtask

   task automatic at(input real t);
      if (t > $realtime) #(t - $realtime);
   endtask

   initial begin
      real          t;
      bit           rc;
      logic [W-1:0] rs, rr;

      clk = 1'b0; reset = 1'b0; set = '0; clr = '0;
      m_ready = 1'b0;
      model_clear();

      // Pulses before BEGIN_TIME are ignored.
      at(5.0);  apply(1'b1, '0, '0);
      at(5.5);  check_all("init_clk", 1'b0);
      at(6.0);  apply(1'b0, 4'b0001, '0);
      at(6.5);  check_all("init_set", 1'b0);
      at(8.5);  check_all("begin", 1'b1);

      // Readout: NDRO keeps state, DRO clears it.
      at(20.0); apply(1'b0, 4'b0110, '0);
      at(20.5); check_all("set12", 1'b1);
      at(30.0); apply(1'b1, '0, '0);
      at(30.5); check_all("clk30", 1'b1);
      at(37.5); check_all("out37", 1'b1);
      at(40.0); apply(1'b1, '0, '0);
      at(40.5); check_all("clk40", 1'b1);
      at(47.5); check_all("out47", 1'b1);

      // Hold windows.
      at(50.0); apply(1'b0, '0, 4'b0001);
      at(50.5); check_all("clr50", 1'b1);
      at(51.0); apply(1'b0, 4'b0001, '0);
      at(51.5); check_all("set51", 1'b1);
      at(60.0); apply(1'b1, '0, '0);
      at(60.5); check_all("clk60", 1'b1);
      at(61.0); apply(1'b0, '0, 4'b0001);
      at(61.5); check_all("clr61", 1'b1);
      at(67.5); check_all("out67", 1'b1);

      // Reset cancels in-flight readouts and masks pulses.
      at(120.0); apply(1'b0, 4'b1000, '0);
      at(130.0); apply(1'b1, '0, '0);
      at(132.0); reset = 1'b1; do_reset_model();
      at(132.5); check_all("rst", 1'b1);
      at(133.0); apply(1'b0, 4'b1000, '0);
      at(133.5); check_all("rst_set", 1'b1);
      at(135.0); reset = 1'b0;
      at(137.5); check_all("rst_out", 1'b1);

      // Simultaneous set/clr pairs: clr wins, counter saturates on the narrow instance.
      for (int k = 0; k < 5; k++) begin
         at(150.0 + 10.0 * k); apply(1'b0, 4'b0001, 4'b0001);
         at(150.5 + 10.0 * k); check_all($sformatf("sat%0d", k), 1'b1);
      end

      // Randomised pulse traffic with occasional resets.
      t = 220.0;
      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 39) == 0) begin
            at(t + 0.25); reset = 1'b1; do_reset_model();
            at(t + 0.75); check_all("rnd_rst", 1'b1);
            at(t + 2.25); reset = 1'b0;
            at(t + 2.75); check_all("rnd_rel", 1'b1);
            t = t + 3.0;
         end else begin
            rc = 1'($urandom_range(0, 1));
            rs = W'($urandom & $urandom);
            rr = W'($urandom & $urandom & $urandom);
            at(t);       apply(rc, rs, rr);
            at(t + 0.5); check_all("rnd", 1'b1);
            t = t + real'($urandom_range(1, 5));
         end
      end
      at(t + 10.5); check_all("drain", 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
